// File: rtl/car_request_conditioner.sv
// car_request_conditioner
//   Conditions the raw road-side car sensor for the traffic light controller:
//   two-flop synchroniser, counter-based debouncer, registered arrival pulse,
//   and a two-state request latch that holds until the controller serves it.
//
//   Optional feature macro: CAR_COUNT_EN
//     defined   -> car_count counts debounced arrivals, saturating at 2**COUNT_W-1
//     undefined -> no counter logic, car_count is tied to zero
//
//   Request handshake: car_req is the "valid" side and served is the
//   "accept" side. car_req rises one cycle after a debounced arrival
//   (car_edge) and stays high until a served pulse arrives in a cycle with
//   no new arrival. A served pulse while car_req is low is ignored. A new
//   arrival in the same cycle as served wins, so car_req stays high. Arrivals
//   while car_req is already high do not queue.
//
//   The request FSM state is exactly car_req (IDLE=0, PENDING=1), so the
//   state is observable on that output without an extra debug port.
//   Every output comes straight from a flop; there is no combinational path
//   from any input to any output.
module car_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               car_raw,
  input  logic               served,
  output logic               car_req,
  output logic               car_present,
  output logic               car_edge,
  output logic [COUNT_W-1:0] car_count
);

  // Highest debounce count; reaching it with a still-disagreeing sample
  // accepts the new level.
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } req_state_t;

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  req_state_t      state;
  req_state_t      state_next;

  // Two-flop synchroniser for the asynchronous sensor input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= car_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count. car_edge
  // is raised on the same edge that car_present goes 0->1.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt      <= '0;
      car_present <= 1'b0;
      car_edge    <= 1'b0;
    end else begin
      car_edge <= 1'b0;
      if (sync2 == car_present) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        car_present <= sync2;
        car_edge    <= sync2;
        db_cnt      <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request FSM next state: an arrival sets, served clears, and set wins
  // when both occur in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (car_edge) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (served && !car_edge) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign car_req = (state == PENDING);

`ifdef CAR_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // Arrival counter: one step per car_edge, holds at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (car_edge && (count_q != {COUNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign car_count = count_q;
`else
  assign car_count = '0;
`endif

endmodule
